ex_result_buffer: RTL
=====================

// Module: ex_result_buffer
// PURPOSE
//  Execute-stage output buffer sitting directly downstream of the ALU/shifter.
//  - Captures each 16-bit result with its destination register and write enable.
//  - Generates Z/N flags from the captured result.
//  - Holds up to two results in a skid buffer, so the upstream ALU can run at full rate
//    while the memory stage applies back-pressure.
//  - Flush support discards wrong-path results on branch mispredict.
// PARAMETERS
//  DATA_W   16  result width (matches shifter Result)
//  REG_AW   4   destination register index width
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  Flush      in   1       sync discard of all held entries
//  In_Valid   in   1       upstream result valid
//  In_Ready   out  1       buffer can accept this cycle
//  In_Result  in   DATA_W  ALU/shifter result
//  In_Dst     in   REG_AW  destination register
//  In_WrEn    in   1       result is to be written back
//  Out_Valid  out  1       head entry valid
//  Out_Ready  in   1       downstream accepts head
//  Out_Result out  DATA_W  head result
//  Out_Dst    out  REG_AW  head destination
//  Out_WrEn   out  1       head write enable
//  Out_Flags  out  2       {N,Z} of head result
// BEHAVIOUR
//  - Transfer rules:
//    - Push = In_Valid & In_Ready.
//    - Pop = Out_Valid & Out_Ready.
//    - Both are sampled on the rising clk edge.
//  - Entry count: registered, range 0..2. States EMPTY (0), ONE (1), FULL (2).
//  - In_Ready = (count != 2). It is combinational from the count register only, never from Out_Ready.
//  - Out_Valid = (count != 0). The Out_* fields are driven from the head entry registers.
//  - Latency: a pushed result is visible on Out_* the cycle after the push (1 cycle).
//    There is no combinational In->Out path.
//  - Flags are computed at push time and stored with the entry:
//    - Z = (In_Result == 0)
//    - N = In_Result[DATA_W-1]
//  - Transitions:
//    - EMPTY + push                    -> ONE
//    - ONE   + push, no pop            -> FULL
//    - ONE   + push + pop              -> ONE; the new entry becomes head
//    - ONE   + pop, no push            -> EMPTY
//    - FULL  + pop                     -> ONE; the tail moves to head
//    - FULL  + In_Valid                -> no push (In_Ready = 0); upstream holds its data
//  - Order: strictly FIFO; results never reorder or duplicate.
//  - Flush:
//    - Next state is EMPTY.
//    - Flush overrides any same-cycle push and pop.
//    - A flushed entry is never presented again.
//  - Reset (asynchronous, at any time including mid-transfer):
//    - count = 0, Out_Valid = 0, In_Ready = 1.
//    - Out_Result = 0, Out_Dst = 0, Out_WrEn = 0, Out_Flags = 2'b01 (Z set).
//  - Out_* while Out_Valid = 0: hold their last value. Downstream ignores them.
// CONFIGURATION
//  EX_FWD_EN defined:
//  - Adds outputs Fwd_Valid (1), Fwd_Dst (REG_AW) and Fwd_Result (DATA_W).
//  - These forward the youngest held entry with WrEn = 1 (tail if FULL, else head)
//    to the decode-stage bypass muxes.
//  - Fwd_Valid = 0 when EMPTY, when that entry has WrEn = 0, or in the cycle after Flush.
//  - Forwarding is registered state only; a same-cycle push is not forwarded.
//  EX_FWD_EN undefined:
//  - The Fwd_* ports and logic are absent. The other behaviour is identical.
// STRUCTURE
//  - Shared package ex_pkg holds:
//    - DATA_W and REG_AW constants
//    - flag indices FLAG_Z = 0, FLAG_N = 1
//    - typedef ex_entry_t {result, dst, wren, flags}
//    - state enum {EMPTY, ONE, FULL}
//  - One sub-module, ex_flag_gen: combinational, computes {N,Z} from a DATA_W result.
//  - The two entry registers and the count/state logic stay in the top module.
// TESTING
//  1. Reset: rst_n low mid-push holding 16'h1234 -> Out_Valid = 0, In_Ready = 1,
//     Out_Flags = 2'b01, all other Out_* = 0, with no clock edge needed.
//  2. Streaming: Out_Ready = 1; push 16'h0001, 16'h8000, 16'h0000 on consecutive cycles
//     -> each appears one cycle later in order, with Flags 00, 10, 01.
//  3. Back-pressure: Out_Ready = 0; push 16'hAAAA then 16'h5555 -> In_Ready = 0 after
//     the second push; a held third value 16'h7777 is not accepted. Raise Out_Ready
//     -> AAAA, 5555, 7777 appear in order, none lost or duplicated.
//  4. Simultaneous: in ONE holding 16'h0010, push 16'h0020 with Out_Ready = 1
//     -> next cycle the head is 0020, count stays 1.
//  5. Flush: in FULL, assert Flush with In_Valid = 1 (16'hBEEF)
//     -> next cycle Out_Valid = 0; BEEF is never presented.
//  6. EX_FWD_EN: push Dst = 4'd3 / 16'h00FF WrEn = 1, then Dst = 4'd5 WrEn = 0,
//     Out_Ready = 0 -> Fwd_Valid = 1, Fwd_Dst = 3, Fwd_Result = 16'h00FF.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute-stage result buffer: widths, flag bit
// positions, the stored entry layout and the occupancy state encoding.
package ex_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_AW-1:0] dst;
    logic              wren;
    logic [1:0]        flags;
  } ex_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ex_state_t;

  // Head value seen on Out_* straight after reset: zero result, so only Z set.
  function automatic ex_entry_t entry_reset();
    ex_entry_t e;
    e.result = '0;
    e.dst    = '0;
    e.wren   = 1'b0;
    e.flags  = 2'b01;
    return e;
  endfunction

endpackage

// File: rtl/ex_result_buffer_if.sv
// Upstream/downstream handshake bundle of the execute-stage result buffer.
// master: the surrounding pipeline (drives In_*, Out_Ready).
// slave : the buffer itself.
// With EX_FWD_EN defined the bundle also carries the decode bypass outputs.
interface ex_result_buffer_if;
  import ex_pkg::*;

  logic              In_Valid;
  logic              In_Ready;
  logic [DATA_W-1:0] In_Result;
  logic [REG_AW-1:0] In_Dst;
  logic              In_WrEn;

  logic              Out_Valid;
  logic              Out_Ready;
  logic [DATA_W-1:0] Out_Result;
  logic [REG_AW-1:0] Out_Dst;
  logic              Out_WrEn;
  logic [1:0]        Out_Flags;

`ifdef EX_FWD_EN
  logic              Fwd_Valid;
  logic [REG_AW-1:0] Fwd_Dst;
  logic [DATA_W-1:0] Fwd_Result;

  modport master (
    output In_Valid, In_Result, In_Dst, In_WrEn, Out_Ready,
    input  In_Ready, Out_Valid, Out_Result, Out_Dst, Out_WrEn, Out_Flags,
    input  Fwd_Valid, Fwd_Dst, Fwd_Result
  );

  modport slave (
    input  In_Valid, In_Result, In_Dst, In_WrEn, Out_Ready,
    output In_Ready, Out_Valid, Out_Result, Out_Dst, Out_WrEn, Out_Flags,
    output Fwd_Valid, Fwd_Dst, Fwd_Result
  );
`else
  modport master (
    output In_Valid, In_Result, In_Dst, In_WrEn, Out_Ready,
    input  In_Ready, Out_Valid, Out_Result, Out_Dst, Out_WrEn, Out_Flags
  );

  modport slave (
    input  In_Valid, In_Result, In_Dst, In_WrEn, Out_Ready,
    output In_Ready, Out_Valid, Out_Result, Out_Dst, Out_WrEn, Out_Flags
  );
`endif

endinterface

// File: rtl/ex_flag_gen.sv
// Combinational {N,Z} flag generation for one result word.
module ex_flag_gen
  import ex_pkg::*;
(
  input  logic [DATA_W-1:0] result_i,
  output logic [1:0]        flags_o
);

  // Z when the whole word is zero, N from the sign bit.
  always_comb begin
    flags_o         = 2'b00;
    flags_o[FLAG_Z] = (result_i == '0);
    flags_o[FLAG_N] = result_i[DATA_W-1];
  end

endmodule

// File: rtl/ex_result_buffer.sv
// Execute-stage two-entry skid buffer between the ALU/shifter and the memory
// stage. Results are stored with destination, write enable and {N,Z} flags
// computed at capture time, and leave in strict FIFO order one cycle after
// capture at the earliest. Flush discards everything held.
// Optional feature macro: EX_FWD_EN adds the Fwd_* bypass outputs.
module ex_result_buffer
  import ex_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Flush,
  ex_result_buffer_if.slave  bus
);

  ex_state_t  state_q, state_d;
  ex_entry_t  head_q,  head_d;
  ex_entry_t  tail_q,  tail_d;
  ex_entry_t  in_entry;
  logic [1:0] in_flags;
  logic       push;
  logic       pop;

  ex_flag_gen u_flag_gen (
    .result_i (bus.In_Result),
    .flags_o  (in_flags)
  );

  // Handshake depends on the occupancy register only, never on Out_Ready,
  // so the upstream ready path stays short.
  assign bus.In_Ready  = (state_q != FULL);
  assign bus.Out_Valid = (state_q != EMPTY);

  assign push = bus.In_Valid  & bus.In_Ready;
  assign pop  = bus.Out_Valid & bus.Out_Ready;

  // Assemble the entry that would be captured this cycle.
  always_comb begin
    in_entry.result = bus.In_Result;
    in_entry.dst    = bus.In_Dst;
    in_entry.wren   = bus.In_WrEn;
    in_entry.flags  = in_flags;
  end

  // Occupancy and entry next-state; flush wins over any push/pop and leaves
  // the head contents as they were (Out_* hold while not valid).
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (Flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d  = in_entry;
          end else if (push) begin
            tail_d  = in_entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Head entry drives Out_*, so it carries a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= entry_reset();
    end else begin
      head_q <= head_d;
    end
  end

  // Tail entry is only read once it has been written, so it needs no reset.
  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

  assign bus.Out_Result = head_q.result;
  assign bus.Out_Dst    = head_q.dst;
  assign bus.Out_WrEn   = head_q.wren;
  assign bus.Out_Flags  = head_q.flags;

`ifdef EX_FWD_EN
  // Youngest held writer from registered state: tail when it writes back,
  // otherwise head; nothing once the buffer is empty (including after Flush).
  always_comb begin
    bus.Fwd_Valid  = 1'b0;
    bus.Fwd_Dst    = '0;
    bus.Fwd_Result = '0;
    if (state_q == FULL && tail_q.wren) begin
      bus.Fwd_Valid  = 1'b1;
      bus.Fwd_Dst    = tail_q.dst;
      bus.Fwd_Result = tail_q.result;
    end else if (state_q != EMPTY && head_q.wren) begin
      bus.Fwd_Valid  = 1'b1;
      bus.Fwd_Dst    = head_q.dst;
      bus.Fwd_Result = head_q.result;
    end
  end
`endif

endmodule
